// File: rtl/poly_synth.sv
`default_nettype none
// ============================================================================
// Module   : poly_synth
// Brief    : N-voice square/saw synth with linear ADSR per voice, mixed by one
//            shared time-multiplexed MAC into a signed PCM stream.
//            Optional define POLY_SYNTH_MIX_NORM_EN: scale mix by 1/VOICES.
// Revision : 1.0 - initial release
// ============================================================================
module poly_synth #(
    parameter int VOICES     = 4,
    parameter int OSC_W      = 12,
    parameter int SAMPLE_DIV = 512,
    parameter int ADSR_DIV   = 512,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VOICES-1:0]       trig,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_voice,
    input  logic [2:0]              cfg_addr,
    input  logic [OSC_W-1:0]        cfg_data,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic [VOICES-1:0]       voice_active
);
    localparam int c_LOGV = $clog2(VOICES);
    localparam int c_VW   = (VOICES > 1) ? c_LOGV : 1;
    localparam int c_AW   = OUT_W + c_LOGV;
    localparam int c_SW   = $clog2(SAMPLE_DIV + 1);
    localparam int c_EW   = $clog2(ADSR_DIV + 1);
    localparam logic [c_SW-1:0] c_SMAX = c_SW'(SAMPLE_DIV - 1);
    localparam logic [c_EW-1:0] c_EMAX = c_EW'(ADSR_DIV - 1);
    localparam logic signed [c_AW-1:0] c_PMAX = {{(c_LOGV+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_NMAX = {{(c_LOGV+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } adsr_state_t;

    logic [OSC_W-1:0]  r_inc   [VOICES];
    logic [7:0]        r_ai    [VOICES];
    logic [7:0]        r_di    [VOICES];
    logic [7:0]        r_s     [VOICES];
    logic [7:0]        r_ri    [VOICES];
    logic [VOICES-1:0] r_wave;
    logic [OSC_W-1:0]  r_phase [VOICES];
    logic [7:0]        r_env   [VOICES];
    adsr_state_t       r_state [VOICES];
    logic [VOICES-1:0] r_gate;
    logic [c_SW-1:0]   r_sdiv;
    logic [c_EW-1:0]   r_ediv;

    logic w_stick, w_etick;
    assign w_stick = (r_sdiv == c_SMAX);
    assign w_etick = w_stick && (r_ediv == c_EMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wave <= '0;
            for (int v = 0; v < VOICES; v++) begin
                r_inc[v] <= '0;
                r_ai[v]  <= '0;
                r_di[v]  <= '0;
                r_s[v]   <= '0;
                r_ri[v]  <= '0;
            end
        end else if (cfg_we) begin
            // Voice numbers beyond VOICES never match, so those writes drop out.
            for (int v = 0; v < VOICES; v++) begin
                if (cfg_voice == 4'(v)) begin
                    case (cfg_addr)
                        3'd0:    r_inc[v]  <= cfg_data;
                        3'd1:    r_ai[v]   <= cfg_data[7:0];
                        3'd2:    r_di[v]   <= cfg_data[7:0];
                        3'd3:    r_s[v]    <= cfg_data[7:0];
                        3'd4:    r_ri[v]   <= cfg_data[7:0];
                        3'd5:    r_wave[v] <= cfg_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [8:0]        w_att [VOICES];
    logic signed [9:0] w_dec [VOICES];
    logic signed [9:0] w_rel [VOICES];
    logic signed [7:0] w_osc [VOICES];

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            w_att[v] = {1'b0, r_env[v]} + {1'b0, r_ai[v]};
            w_dec[v] = $signed({2'b00, r_env[v]}) - $signed({2'b00, r_di[v]});
            w_rel[v] = $signed({2'b00, r_env[v]}) - $signed({2'b00, r_ri[v]});
            if (r_wave[v])
                w_osc[v] = {~r_phase[v][OSC_W-1], r_phase[v][OSC_W-2 -: 7]};
            else
                w_osc[v] = r_phase[v][OSC_W-1] ? 8'h80 : 8'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sdiv       <= '0;
            r_ediv       <= '0;
            r_gate       <= '0;
            voice_active <= '0;
            for (int v = 0; v < VOICES; v++) begin
                r_phase[v] <= '0;
                r_env[v]   <= '0;
                r_state[v] <= S_IDLE;
            end
        end else begin
            r_sdiv <= w_stick ? '0 : r_sdiv + c_SW'(1);
            if (w_stick) begin
                r_ediv <= w_etick ? '0 : r_ediv + c_EW'(1);
                r_gate <= trig;
                for (int v = 0; v < VOICES; v++) begin
                    r_phase[v] <= r_phase[v] + r_inc[v];
                    // An edge on the gate consumes this tick; no envelope step.
                    if (trig[v] != r_gate[v]) begin
                        if (trig[v] && (r_state[v] == S_IDLE || r_state[v] == S_RELEASE)) begin
                            r_state[v]      <= S_ATTACK;
                            voice_active[v] <= 1'b1;
                        end else if (!trig[v] && (r_state[v] == S_ATTACK ||
                                     r_state[v] == S_DECAY || r_state[v] == S_SUSTAIN)) begin
                            r_state[v] <= S_RELEASE;
                        end
                    end else if (w_etick) begin
                        case (r_state[v])
                            S_ATTACK: begin
                                if (r_ai[v] == 8'd0 || w_att[v] >= 9'd255) begin
                                    r_env[v]   <= 8'hFF;
                                    r_state[v] <= S_DECAY;
                                end else begin
                                    r_env[v] <= w_att[v][7:0];
                                end
                            end
                            S_DECAY: begin
                                if (r_di[v] == 8'd0 || w_dec[v] <= $signed({2'b00, r_s[v]})) begin
                                    r_env[v]   <= r_s[v];
                                    r_state[v] <= S_SUSTAIN;
                                end else begin
                                    r_env[v] <= w_dec[v][7:0];
                                end
                            end
                            S_SUSTAIN: r_env[v] <= r_s[v];
                            S_RELEASE: begin
                                if (r_ri[v] == 8'd0 || w_rel[v] <= 10'sd0) begin
                                    r_env[v]        <= 8'd0;
                                    r_state[v]      <= S_IDLE;
                                    voice_active[v] <= 1'b0;
                                end else begin
                                    r_env[v] <= w_rel[v][7:0];
                                end
                            end
                            default: r_env[v] <= 8'd0;
                        endcase
                    end
                end
            end
        end
    end

    logic [c_VW-1:0]          r_mac_idx;
    logic                     r_mac_busy;
    logic signed [c_AW-1:0]   r_acc;
    logic signed [7:0]        w_osc_sel;
    logic signed [8:0]        w_env_sel;
    logic signed [16:0]       w_prod;
    logic signed [c_AW-1:0]   w_sum;
    logic signed [c_AW-1:0]   w_scaled;
    logic signed [OUT_W-1:0]  w_sat;

    assign w_osc_sel = w_osc[r_mac_idx];
    assign w_env_sel = $signed({1'b0, r_env[r_mac_idx]});
    assign w_prod    = 17'(w_osc_sel) * 17'(w_env_sel);
    assign w_sum     = r_acc + c_AW'(w_prod);

`ifdef POLY_SYNTH_MIX_NORM_EN
    assign w_scaled = w_sum >>> c_LOGV;
`else
    assign w_scaled = w_sum;
`endif

    always_comb begin
        if (w_scaled > c_PMAX)
            w_sat = c_PMAX[OUT_W-1:0];
        else if (w_scaled < c_NMAX)
            w_sat = c_NMAX[OUT_W-1:0];
        else
            w_sat = w_scaled[OUT_W-1:0];
    end

    // Voice k is summed in cycle T+1+k; the final sum is registered at T+VOICES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac_busy   <= 1'b0;
            r_mac_idx    <= '0;
            r_acc        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (w_stick) begin
                r_mac_busy <= 1'b1;
                r_mac_idx  <= '0;
                r_acc      <= '0;
            end else if (r_mac_busy) begin
                r_acc     <= w_sum;
                r_mac_idx <= r_mac_idx + c_VW'(1);
                if (r_mac_idx == c_VW'(VOICES - 1)) begin
                    r_mac_busy   <= 1'b0;
                    sample_out   <= w_sat;
                    sample_valid <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_poly_synth.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_synth
// Brief    : Directed self-checking bench for poly_synth (4 voices, fast ticks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_synth;
    localparam int VOICES     = 4;
    localparam int OSC_W      = 12;
    localparam int SAMPLE_DIV = 16;
    localparam int ADSR_DIV   = 1;
    localparam int OUT_W      = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [VOICES-1:0]       trig = '0;
    logic                    cfg_we = 1'b0;
    logic [3:0]              cfg_voice = '0;
    logic [2:0]              cfg_addr = '0;
    logic [OSC_W-1:0]        cfg_data = '0;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic [VOICES-1:0]       voice_active;

    poly_synth #(
        .VOICES(VOICES), .OSC_W(OSC_W), .SAMPLE_DIV(SAMPLE_DIV),
        .ADSR_DIV(ADSR_DIV), .OUT_W(OUT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .trig(trig), .cfg_we(cfg_we),
        .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .voice_active(voice_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected output for a given raw mix sum of 4 voices.
    function automatic int mix(input int acc);
        int a;
        a = acc;
`ifdef POLY_SYNTH_MIX_NORM_EN
        a = a >>> 2;
`endif
        if (a > 32767)  a = 32767;
        if (a < -32768) a = -32768;
        return a;
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        trig   = '0;
        cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input int v, input int a, input int d);
        cfg_voice = 4'(v);
        cfg_addr  = 3'(a);
        cfg_data  = OSC_W'(d);
        cfg_we    = 1'b1;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic wait_valid(output int val);
        val = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                val = int'(sample_out);
                return;
            end
        end
        check_val("valid_timeout", 0, 1);
    endtask

    int env_tab[30] = '{0, 64, 128, 192, 255, 223, 191, 159, 128, 128,
                        128, 112, 96, 96, 160, 224, 255, 223, 191, 159, 128,
                        128, 112, 96, 80, 64, 48, 32, 16, 0};

    initial begin
        int smp;
        int n;
        int bad;

        // Reset state and sample cadence.
        do_reset();
        check_val("rst_out", int'(sample_out), 0);
        check_val("rst_valid", int'(sample_valid), 0);
        check_val("rst_active", int'(voice_active), 0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                n = i;
                break;
            end
        end
        check_val("first_valid_cycle", n, 20);
        @(posedge clk);
        #1 check_val("valid_pulse", int'(sample_valid), 0);
        n = 0;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                n = i;
                break;
            end
        end
        check_val("valid_period", n, 16);
        check_val("idle_out", int'(sample_out), 0);

        // Single square voice, instant attack, full sustain.
        do_reset();
        cfg_write(0, 3, 255);
        cfg_write(0, 0, 'h800);
        trig = 4'b0001;
        wait_valid(smp); check_val("sq0", smp, mix(0));
        wait_valid(smp); check_val("sq1", smp, mix(32385));
        wait_valid(smp); check_val("sq2", smp, mix(-32640));
        wait_valid(smp); check_val("sq3", smp, mix(32385));
        check_val("sq_active", int'(voice_active), 1);

        // Saw waveform.
        do_reset();
        cfg_write(0, 5, 1);
        cfg_write(0, 3, 255);
        cfg_write(0, 0, 'h100);
        trig = 4'b0001;
        wait_valid(smp); check_val("saw0", smp, mix(0));
        wait_valid(smp); check_val("saw1", smp, mix(-24480));
        wait_valid(smp); check_val("saw2", smp, mix(-20400));

        // Full ADSR walk with release retrigger; osc fixed at +127.
        do_reset();
        cfg_write(0, 1, 64);
        cfg_write(0, 2, 32);
        cfg_write(0, 3, 128);
        cfg_write(0, 4, 16);
        trig = 4'b0001;
        for (int i = 0; i < 30; i++) begin
            wait_valid(smp);
            check_val($sformatf("adsr%0d", i), smp, mix(127 * env_tab[i]));
            if (i == 9)  trig = 4'b0000;
            if (i == 12) begin
                check_val("rel_active", int'(voice_active), 1);
                trig = 4'b0001;
            end
            if (i == 20) trig = 4'b0000;
        end
        check_val("idle_active", int'(voice_active), 0);

        // Four identical voices driving the mix into saturation.
        do_reset();
        for (int v = 0; v < 4; v++) begin
            cfg_write(v, 3, 255);
            cfg_write(v, 0, 'h800);
        end
        trig = 4'b1111;
        wait_valid(smp); check_val("mix0", smp, mix(0));
        wait_valid(smp); check_val("mix_pos", smp, mix(4 * 32385));
        wait_valid(smp); check_val("mix_neg", smp, mix(-4 * 32640));
        check_val("mix_active", int'(voice_active), 15);

        // Out-of-range voice writes, then an inc write inside the MAC window.
        do_reset();
        cfg_write(1, 3, 255);
        cfg_write(5, 0, 'h800);
        cfg_write(5, 3, 0);
        trig = 4'b0010;
        wait_valid(smp); check_val("v5_0", smp, mix(0));
        wait_valid(smp); check_val("v5_1", smp, mix(32385));
        wait_valid(smp); check_val("v5_2", smp, mix(32385));
        repeat (12) @(posedge clk);
        #1 cfg_write(1, 0, 'h800);
        wait_valid(smp); check_val("macw_0", smp, mix(32385));
        wait_valid(smp); check_val("macw_1", smp, mix(-32640));
        wait_valid(smp); check_val("macw_2", smp, mix(32385));

        // Reset landing inside the MAC window.
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("rstmac_out", int'(sample_out), 0);
        check_val("rstmac_active", int'(voice_active), 0);
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (sample_valid) bad++;
        end
        check_val("rstmac_valid", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
